f_stage_fq: RTL
===============

# f_stage_fq

Parametrised fetch stage with a decoupled instruction-memory request/response interface and an in-order fetch queue. Sits at the front of the core pipeline, ahead of decode. It issues sequential fetches from a fetch PC and keeps up to `MAX_OUTSTANDING` requests in flight. Returned instructions are buffered in a `FQ_DEPTH`-entry queue. On a jal/branch/jalr redirect it flushes the queue and discards stale in-flight responses.

## Interface
- `N_BITS`, 32: address/PC width.
- `RST_PC`, 32'h00000000: address of first fetch after reset.
- `FQ_DEPTH`, 4: queue entries; power of 2, ≥2.
- `MAX_OUTSTANDING`, 2: max accepted-but-unanswered imem requests; 1..FQ_DEPTH.
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: asynchronous active-low reset.
- Redirect inputs:
  - `jal_vld`/`jal_tgt` in 1/N_BITS: jal redirect.
  - `branch_vld`/`branch_tgt` in 1/N_BITS: taken-branch redirect.
  - `jalr_vld`/`jalr_tgt` in 1/N_BITS: jalr redirect.
- Instruction-memory request/response:
  - `imem_req_vld` out 1: fetch request valid.
  - `imem_req_rdy` in 1: memory accepts the request.
  - `imem_req_addr` out N_BITS: fetch address (= fetch PC).
  - `imem_resp_vld` in 1: in-order response. At most one per cycle, no earlier than 1 cycle after acceptance.
  - `imem_resp_data` in 32: instruction word.
- Downstream:
  - `vld` out 1: head entry valid to decode.
  - `inst` out 32: head instruction.
  - `pc`, `pc_plus4` out N_BITS: head PC and head PC + 4.
  - `stall_in` in 1: decode not accepting.
  - `squash` out 1: high in any redirect cycle.

## Operation
- Redirect priority is jalr > branch > jal. `redirect` = OR of the three valids.
- State:
  - `fpc` resets to RST_PC.
  - Pointers `alloc`, `fill`, `head` have log2(FQ_DEPTH)+1 bits and wrap naturally; all reset to 0.
  - `out_cnt` counts total outstanding requests; `drop_cnt` counts stale responses pending. Both reset to 0.
  - Entry fields `pc`, `inst`, `full` reset to 0.
- Issue rule:
  - `imem_req_vld` = rst_n && !redirect && (alloc−head) < FQ_DEPTH && out_cnt < MAX_OUTSTANDING.
  - On handshake: entry[alloc].pc ← fpc, full ← 0; alloc++; fpc ← fpc+4; out_cnt++.
- Response rule (`imem_resp_vld`):
  - Always: out_cnt--.
  - If drop_cnt>0: drop_cnt-- and data discarded.
  - Else: entry[fill].inst ← data, full ← 1; fill++.
  - Issue and response in the same cycle leave out_cnt unchanged.
- Dequeue rule:
  - `vld` = entry[head].full && (head≠fill… i.e. head≠alloc) && !redirect.
  - On vld && !stall_in: head++, full cleared.
- Redirect (same cycle, overrides all other updates except out_cnt):
  - fpc ← selected target.
  - head ← fill ← alloc.
  - drop_cnt ← drop_cnt + (out_cnt − drop_cnt) − imem_resp_vld; equivalently, every request outstanding after this cycle becomes stale.
  - out_cnt ← out_cnt − imem_resp_vld; a request cannot issue in this cycle.
  - A response arriving in the redirect cycle is discarded.
- Full queue: no issue while (alloc−head)=FQ_DEPTH. A slot freed by dequeue becomes usable the next cycle.
- Empty queue / unfilled head: vld=0; inst and pc show the head entry's stored (stale) values.
- Reset mid-operation clears all state. Responses for requests issued before reset are not tracked; the memory side is reset together with this block.

## Timing
- Reset values:
  - imem_req_vld=0 while rst_n=0; imem_req_addr=RST_PC.
  - vld=0, inst=0, pc=0, pc_plus4=4, squash=0.
- First request is presented in the first cycle after rst_n deasserts, with addr=RST_PC.
- Latency: request accepted in cycle t, response in t+k (k≥1), vld in t+k+1.
- Throughput: 1 instruction/cycle at k=1 with MAX_OUTSTANDING≥2 and no stall.
- Redirect in cycle r:
  - squash=1 and vld=0 in r.
  - Request to the target is presented in r+1.
  - Earliest vld at the target is r+3 (k=1).
- squash is combinational from the redirect inputs; all other outputs come from state only.

## Configuration
- `F_STAGE_PERF_CNT_EN` defined: adds two outputs, each a 32-bit counter that resets to 0 and wraps at 2^32.
  - `perf_fetch_cnt` out 32: increments on each dequeue.
  - `perf_drop_cnt` out 32: increments on each discarded response, including those discarded in the redirect cycle.
- Not defined: both ports and both counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, memory k=1, always ready, stall_in=0:
  - Requests at addresses 0,4,8,…
  - vld first in the 3rd cycle after reset release, with pc=0.
  - Then one instruction/cycle in order; pc_plus4 = pc+4.
- stall_in=1 held, FQ_DEPTH=4:
  - Exactly 4 requests accepted, then imem_req_vld=0.
  - Release stall → 4 in-order dequeues, and issue resumes the cycle after the first dequeue.
- Memory k=3, 2 requests in flight (0x10, 0x14), branch_vld with tgt=0x100:
  - Both responses discarded (perf_drop_cnt=2 if enabled).
  - First vld has pc=0x100.
- jalr_vld and jal_vld in the same cycle, tgt 0x200 vs 0x300:
  - Next request addr=0x200.
  - squash=1 for one cycle only.
- Redirect coinciding with a response and imem_req_rdy=1:
  - No request issued that cycle.
  - That response is dropped; out_cnt and drop_cnt stay consistent, with no extra drop later.
- Assert rst_n=0 mid-stream with a full queue:
  - vld=0 and imem_req_vld=0 immediately.
  - After release, first request addr=RST_PC.

Source files
------------

// File: rtl/f_stage_fq_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface f_stage_fq_if #(
  parameter int N_BITS = 32
);
  // Request: transfers when imem_req_vld && imem_req_rdy at a rising clk edge.
  // imem_req_vld never depends on imem_req_rdy. Response: imem_resp_vld is a
  // one-cycle, in-order pulse with no back-pressure.
  logic              imem_req_vld;
  logic              imem_req_rdy;
  logic [N_BITS-1:0] imem_req_addr;
  logic              imem_resp_vld;
  logic [31:0]       imem_resp_data;

  modport master (
    output imem_req_vld,
    output imem_req_addr,
    input  imem_req_rdy,
    input  imem_resp_vld,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_vld,
    input  imem_req_addr,
    output imem_req_rdy,
    output imem_resp_vld,
    output imem_resp_data
  );
endinterface

// File: rtl/f_stage_fq.sv
// Fetch stage: sequential imem fetches, in-order fetch queue, redirect flush.
// Optional F_STAGE_PERF_CNT_EN adds fetch/drop event counters.
module f_stage_fq #(
  parameter int                N_BITS          = 32,
  parameter logic [N_BITS-1:0] RST_PC          = '0,
  parameter int                FQ_DEPTH        = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jal_vld,
  input  logic [N_BITS-1:0] jal_tgt,
  input  logic              branch_vld,
  input  logic [N_BITS-1:0] branch_tgt,
  input  logic              jalr_vld,
  input  logic [N_BITS-1:0] jalr_tgt,
  f_stage_fq_if.master      imem,
  output logic              vld,
  output logic [31:0]       inst,
  output logic [N_BITS-1:0] pc,
  output logic [N_BITS-1:0] pc_plus4,
  input  logic              stall_in,
  output logic              squash
`ifdef F_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  localparam int IW = $clog2(FQ_DEPTH);
  localparam int PW = IW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [OW-1:0] cnt_t;

  logic [N_BITS-1:0] fpc;
  ptr_t              alloc;
  ptr_t              fill;
  ptr_t              head;
  cnt_t              out_cnt;
  cnt_t              drop_cnt;

  logic [N_BITS-1:0] ent_pc   [FQ_DEPTH];
  logic [31:0]       ent_inst [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] ent_full;

  logic              redirect;
  logic [N_BITS-1:0] redirect_tgt;
  ptr_t              occ;
  logic              issue_ok;
  logic              issue;
  logic              resp;
  logic              resp_drop;
  logic              resp_fill;
  logic              deq;
  logic [IW-1:0]     head_idx;
  logic [IW-1:0]     fill_idx;
  logic [IW-1:0]     alloc_idx;

  always_comb begin
    redirect     = jal_vld | branch_vld | jalr_vld;
    redirect_tgt = jal_tgt;
    if (jalr_vld) begin
      redirect_tgt = jalr_tgt;
    end else if (branch_vld) begin
      redirect_tgt = branch_tgt;
    end

    head_idx  = head[IW-1:0];
    fill_idx  = fill[IW-1:0];
    alloc_idx = alloc[IW-1:0];
    occ       = alloc - head;

    // rst_n gates the request so it drops the instant reset asserts.
    issue_ok = rst_n && !redirect && (occ < ptr_t'(FQ_DEPTH))
               && (out_cnt < cnt_t'(MAX_OUTSTANDING));
    issue    = issue_ok && imem.imem_req_rdy;

    resp      = imem.imem_resp_vld;
    resp_drop = resp && (redirect || (drop_cnt != '0));
    resp_fill = resp && !resp_drop;

    // head != fill is implied by a set full bit; kept as a cheap cross-check.
    vld = ent_full[head_idx] && (head != alloc) && (head != fill) && !redirect;
    deq = vld && !stall_in;
  end

  assign imem.imem_req_vld  = issue_ok;
  assign imem.imem_req_addr = fpc;
  assign inst               = ent_inst[head_idx];
  assign pc                 = ent_pc[head_idx];
  assign pc_plus4           = ent_pc[head_idx] + N_BITS'(4);
  assign squash             = redirect;

  // Control state. A redirect overrides everything except the out_cnt update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc      <= RST_PC;
      alloc    <= '0;
      fill     <= '0;
      head     <= '0;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case ({issue, resp})
        2'b10:   out_cnt <= out_cnt + cnt_t'(1);
        2'b01:   out_cnt <= out_cnt - cnt_t'(1);
        default: out_cnt <= out_cnt;
      endcase

      if (redirect) begin
        fpc      <= redirect_tgt;
        head     <= alloc;
        fill     <= alloc;
        // Everything still outstanding after this cycle is stale.
        drop_cnt <= out_cnt - cnt_t'(resp);
      end else begin
        if (issue) begin
          alloc <= alloc + ptr_t'(1);
          fpc   <= fpc + N_BITS'(4);
        end
        if (resp_fill) begin
          fill <= fill + ptr_t'(1);
        end
        if (resp && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - cnt_t'(1);
        end
        if (deq) begin
          head <= head + ptr_t'(1);
        end
      end
    end
  end

  // Queue entries. issue/resp_fill/deq are all low during a redirect, and
  // the three indices never collide on the same entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        ent_pc[i]   <= '0;
        ent_inst[i] <= '0;
      end
      ent_full <= '0;
    end else begin
      if (deq) begin
        ent_full[head_idx] <= 1'b0;
      end
      if (resp_fill) begin
        ent_inst[fill_idx] <= imem.imem_resp_data;
        ent_full[fill_idx] <= 1'b1;
      end
      if (issue) begin
        ent_pc[alloc_idx]   <= fpc;
        ent_full[alloc_idx] <= 1'b0;
      end
    end
  end

`ifdef F_STAGE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (deq) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (resp_drop) begin
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
      end
    end
  end
`endif

  // Bookkeeping invariants.
  a_out_cnt_max : assert property (@(posedge clk) disable iff (!rst_n)
    out_cnt <= cnt_t'(MAX_OUTSTANDING));
  a_drop_le_out : assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt <= out_cnt);
  a_occ_max : assert property (@(posedge clk) disable iff (!rst_n)
    occ <= ptr_t'(FQ_DEPTH));
  a_resp_has_req : assert property (@(posedge clk) disable iff (!rst_n)
    imem.imem_resp_vld |-> (out_cnt != '0));

endmodule
